mux_rr_arbiter: RTL

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

---
 rtl/mux_rr_arbiter_pkg.sv | 10 +
 rtl/mux_rr_arbiter_if.sv | 22 ++
 rtl/mux_rr_arbiter_rr_pick.sv | 30 +++
 rtl/mux_rr_arbiter.sv | 103 ++++++++++
 4 files changed

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants and state encoding for the round-robin mux arbiter.
package mux_arb_pkg;
    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;
endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester bus for the mux arbiter: request/data in, grant/select/mux output back.
interface mux_rr_arbiter_if;
    import mux_arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] data_in;
    logic [N_REQ-1:0] gnt;
    logic [SEL_W-1:0] sel;
    logic             out;
    logic             out_valid;
    logic [SEL_W-1:0] out_src;

    modport master (
        output req, data_in,
        input  gnt, sel, out, out_valid, out_src
    );

    modport slave (
        input  req, data_in,
        output gnt, sel, out, out_valid, out_src
    );
endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Round-robin picker: first set request scanning upward from ptr+1 with wrap.
// With excl set, the requester at ptr (the current owner) is masked out.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             excl,
    output logic             found,
    output logic [SEL_W-1:0] idx
);
    logic [N_REQ-1:0] masked;
    logic [SEL_W-1:0] cand;

    // Scan from the farthest offset down so the nearest candidate after ptr wins.
    always_comb begin
        found  = 1'b0;
        idx    = ptr;
        cand   = '0;
        masked = req;
        if (excl) masked[ptr] = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = ptr + SEL_W'(k);
            if (masked[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end
endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving an 8:1 single-bit mux, with a per-owner burst
// limit that only forces a handover when someone else is waiting.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_BURST = 16
) (
    input  logic             clk,
    input  logic             rst,
    mux_rr_arbiter_if.slave  bus
);
    localparam int             BW         = $clog2(MAX_BURST);
    localparam logic [BW-1:0]  BURST_LAST = BW'(MAX_BURST - 1);

    arb_state_e       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             out_q, vld_q;
    logic [SEL_W-1:0] src_q;

    logic             pick_excl;
    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;

    // While busy ptr equals the owner, so masking ptr excludes the owner.
    assign pick_excl = (state_q == BUSY);

    rr_pick u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .excl  (pick_excl),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Next owner / burst count; every owner change reloads the count and ptr.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        bcnt_d  = bcnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = BUSY;
                    sel_d   = pick_idx;
                    ptr_d   = pick_idx;
                    bcnt_d  = '0;
                end
            end
            BUSY: begin
                if (bus.req[sel_q]) begin
                    if (bcnt_q != BURST_LAST) begin
                        bcnt_d = bcnt_q + BW'(1);
                    end else if (pick_found) begin
                        sel_d  = pick_idx;
                        ptr_d  = pick_idx;
                        bcnt_d = '0;
                    end
                end else if (pick_found) begin
                    sel_d  = pick_idx;
                    ptr_d  = pick_idx;
                    bcnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        gnt_d = (state_d == BUSY) ? (N_REQ'(1) << sel_d) : '0;
    end

    // State, grant and one-cycle-delayed mux output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= SEL_W'(N_REQ - 1);
            bcnt_q  <= '0;
            gnt_q   <= '0;
            out_q   <= 1'b0;
            vld_q   <= 1'b0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            bcnt_q  <= bcnt_d;
            gnt_q   <= gnt_d;
            out_q   <= bus.data_in[sel_q];
            vld_q   <= (|gnt_q) & bus.req[sel_q];
            src_q   <= sel_q;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.out       = out_q;
    assign bus.out_valid = vld_q;
    assign bus.out_src   = src_q;
endmodule
